// File: rtl/store_merge_unit_if.sv
// -----------------------------------------------------------------------------
// store_merge_unit_if
//
// Word-addressed data-memory port used by store_merge_unit. One transfer is a
// req/ack handshake: the requester holds mem_req together with a stable
// mem_we/mem_addr/mem_wdata until it samples mem_ack high on a rising clock
// edge. On a read, mem_rdata is valid in the same cycle as mem_ack.
//
// Signals:
//   mem_req    requester -> memory  transfer request, held until mem_ack
//   mem_we     requester -> memory  1 write, 0 read (valid while mem_req)
//   mem_addr   requester -> memory  32-bit word address (bits [1:0] are zero)
//   mem_wdata  requester -> memory  32-bit write data
//   mem_rdata  memory -> requester  32-bit read data, valid with mem_ack
//   mem_ack    memory -> requester  transfer completion
//
// Modports:
//   master  the store unit (drives the request)
//   slave   the memory (answers the request)
// -----------------------------------------------------------------------------
interface store_merge_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/store_merge_unit.sv
// -----------------------------------------------------------------------------
// store_merge_unit
//
// Store path from the execute stage to word-addressed data memory. A store of
// size byte, half word or word is accepted from the core; the register value
// is truncated to that size and written into the addressed word. Byte and
// half-word stores read the word first and merge the new lane into it
// (little-endian), so the untouched lanes are preserved. Word stores are a
// single write. Double-word size is rejected with an err pulse and no memory
// access.
//
// Optional feature (macro STORE_ALIGN_CHECK_EN):
//   defined     half with addr[0]=1, or word with addr[1:0]!=0, is rejected
//               with err and no memory access.
//   undefined   no alignment check; half uses addr[1] only, word ignores
//               addr[1:0]; err is raised for dataSize 2'b11 only.
//
// Ports:
//   CLK       in   clock, rising edge
//   CLR       in   asynchronous active-low reset
//   start     in   store request, sampled only in IDLE
//   addr      in   32-bit byte address of the store
//   D         in   32-bit register data
//   dataSize  in   00 byte, 01 half, 10 word, 11 double (unsupported)
//   busy      out  high from the cycle after an accepted start until IDLE
//   done      out  one-cycle pulse, store committed to memory
//   err       out  one-cycle pulse, store rejected
//   mem       memory port (store_merge_unit_if.master)
//
// Timing (zero-wait memory): word done 2 cycles after the start edge,
// byte/half 3 cycles; each memory wait cycle adds one. mem_req rises one
// cycle after the RD/WR state is entered; the RD->WR step keeps mem_req high
// and switches to a write on the same word. All outputs are registered.
// -----------------------------------------------------------------------------
module store_merge_unit (
  input  logic                      CLK,
  input  logic                      CLR,
  input  logic                      start,
  input  logic [31:0]               addr,
  input  logic [31:0]               D,
  input  logic [1:0]                dataSize,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  store_merge_unit_if.master        mem
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    DONE,
    ERR
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_DBL  = 2'b11
  } size_e;

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_e      state_q,  state_d;
  logic        busy_q,   busy_d;
  logic        done_q,   done_d;
  logic        err_q,    err_d;
  logic        req_q,    req_d;
  logic        we_q,     we_d;
  logic [31:0] maddr_q,  maddr_d;
  logic [31:0] wdata_q,  wdata_d;

  // Store operands captured at acceptance; later changes on the core inputs
  // have no effect on the transaction in flight.
  logic [31:0] data_q,   data_d;
  size_e       size_q,   size_d;
  logic [1:0]  lane_q,   lane_d;

  size_e       size_in;
  logic        misaligned;
  logic        ack_hs;

  assign size_in = size_e'(dataSize);

`ifdef STORE_ALIGN_CHECK_EN
  assign misaligned = ((size_in == SZ_HALF) && addr[0]) ||
                      ((size_in == SZ_WORD) && (addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // A completion only counts while our own request is visible to memory;
  // an ack with mem_req low is ignored.
  assign ack_hs = req_q & mem.mem_ack;

  // Little-endian lane merge: the new byte/half replaces its lane of the word
  // read from memory; all other bits come from the read data.
  function automatic logic [31:0] merge_lane(input logic [31:0] rdata,
                                             input logic [31:0] data,
                                             input size_e       size,
                                             input logic [1:0]  lane);
    logic [31:0] merged;
    merged = rdata;
    if (size == SZ_BYTE) begin
      merged[{lane, 3'b000} +: 8] = data[7:0];
    end else begin
      merged[{lane[1], 4'b0000} +: 16] = data[15:0];
    end
    return merged;
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written below gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    req_d   = req_q;
    we_d    = we_q;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    size_d  = size_q;
    lane_d  = lane_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if ((size_in == SZ_DBL) || misaligned) begin
            // Rejected: pulse err now, never touch the memory port.
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            maddr_d = {addr[31:2], 2'b00};
            data_d  = D;
            size_d  = size_in;
            lane_d  = addr[1:0];
            if (size_in == SZ_WORD) begin
              state_d = WR;
              we_d    = 1'b1;
              wdata_d = D;
            end else begin
              state_d = RD;
              we_d    = 1'b0;
            end
          end
        end
      end

      RD: begin
        req_d = 1'b1;
        if (ack_hs) begin
          // Read completes; the write of the merged word follows back-to-back
          // with mem_req kept high.
          wdata_d = merge_lane(mem.mem_rdata, data_q, size_q, lane_q);
          we_d    = 1'b1;
          state_d = WR;
        end
      end

      WR: begin
        req_d = 1'b1;
        if (ack_hs) begin
          req_d   = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      DONE, ERR: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      size_q  <= SZ_BYTE;
      lane_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      size_q  <= size_d;
      lane_q  <= lane_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = maddr_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// -----------------------------------------------------------------------------
// tb_store_merge_unit
//
// Self-checking bench for store_merge_unit. A behavioural memory answers the
// req/ack port with a programmable number of wait cycles and drives random
// ack noise while mem_req is low. Each store is predicted from the size/lane
// rules with plain shifts and masks, then compared on outcome, latency,
// request length, transfer sequence and final memory contents.
// Honours STORE_ALIGN_CHECK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_store_merge_unit;

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic        start = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] D = '0;
  logic [1:0]  dataSize = 2'b00;
  logic        busy, done, err;

  store_merge_unit_if bus ();

  store_merge_unit dut (
    .CLK      (CLK),
    .CLR      (CLR),
    .start    (start),
    .addr     (addr),
    .D        (D),
    .dataSize (dataSize),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .mem      (bus)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  // ---------------------------------------------------------------------------
  // Behavioural memory
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xfer_t;

  logic [31:0] mem_model [logic [31:0]];
  xfer_t       xlog [$];
  int          wait_cfg   = 0;
  int          wcnt       = 0;
  int          req_cycles = 0;

  function automatic logic [31:0] peek(input logic [31:0] a);
    if (!mem_model.exists(a)) mem_model[a] = $urandom;
    return mem_model[a];
  endfunction

  always @(negedge CLK) begin
    if (bus.mem_req === 1'b1) begin
      req_cycles++;
      bus.mem_ack   = (wcnt >= wait_cfg);
      bus.mem_rdata = bus.mem_ack ? peek(bus.mem_addr) : $urandom;
    end else begin
      bus.mem_ack   = 1'($urandom_range(0, 1));
      bus.mem_rdata = $urandom;
    end
  end

  always @(posedge CLK) begin
    if (bus.mem_req === 1'b1 && bus.mem_ack === 1'b1) begin
      xlog.push_back('{we: bus.mem_we, addr: bus.mem_addr, wdata: bus.mem_wdata});
      if (bus.mem_we === 1'b1) mem_model[bus.mem_addr] = bus.mem_wdata;
      wcnt = 0;
    end else if (bus.mem_req === 1'b1) begin
      wcnt++;
    end else begin
      wcnt = 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic bit exp_err(input logic [31:0] a, input logic [1:0] sz);
    bit e;
    e = (sz == 2'd3);
`ifdef STORE_ALIGN_CHECK_EN
    if (sz == 2'd1 && (a % 2) != 0) e = 1'b1;
    if (sz == 2'd2 && (a % 4) != 0) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] old, input logic [31:0] a,
                                           input logic [31:0] d, input logic [1:0] sz);
    int sh;
    case (sz)
      2'd0: begin
        sh = 8 * int'(a % 4);
        return (old & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
      end
      2'd1: begin
        sh = 16 * int'((a / 2) % 2);
        return (old & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
      end
      default: return d;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // One store, end to end
  // ---------------------------------------------------------------------------
  task automatic run_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] sz, input int waits, input bit poke_busy);
    logic [31:0] waddr, old, expw;
    bit          e, seen;
    int          c0, lat, lat_exp, req_exp, nx_exp;

    waddr   = {a[31:2], 2'b00};
    e       = exp_err(a, sz);
    old     = peek(waddr);
    expw    = exp_word(old, a, d, sz);
    lat_exp = e ? 0 : (sz == 2'd2) ? 2 + waits : 3 + 2 * waits;
    req_exp = e ? 0 : (sz == 2'd2) ? 1 + waits : 2 + 2 * waits;
    nx_exp  = e ? 0 : (sz == 2'd2) ? 1 : 2;

    wait_cfg = waits;
    xlog.delete();
    req_cycles = 0;

    @(negedge CLK);
    start = 1'b1; addr = a; D = d; dataSize = sz;
    @(negedge CLK);
    c0 = cyc;
    // Scramble the core inputs: the accepted store must not see them.
    start = 1'b0; addr = $urandom; D = $urandom; dataSize = 2'($urandom_range(0, 3));
    check({tag, ".busy_after_start"}, 32'(busy), 32'd1);

    seen = 1'b0;
    lat  = -1;
    for (int i = 0; i < 60; i++) begin
      if (done === 1'b1 || err === 1'b1) begin
        seen = 1'b1;
        lat  = cyc - c0;
        break;
      end
      // A start raised while busy must be dropped, not queued.
      start = (poke_busy && i == 0) ? 1'b1 : 1'b0;
      @(negedge CLK);
    end
    start = 1'b0;

    check({tag, ".outcome"}, seen ? 32'({done, err}) : 32'hDEAD, e ? 32'h1 : 32'h2);
    check({tag, ".latency"}, 32'(lat), 32'(lat_exp));

    @(negedge CLK);
    check({tag, ".pulse_one_cycle"}, 32'({done, err}), 32'h0);
    check({tag, ".idle_busy"}, 32'(busy), 32'd0);
    check({tag, ".req_cycles"}, 32'(req_cycles), 32'(req_exp));
    check({tag, ".xfer_count"}, 32'(xlog.size()), 32'(nx_exp));
    if (xlog.size() == nx_exp && nx_exp == 2) begin
      check({tag, ".rd_we"}, 32'(xlog[0].we), 32'd0);
      check({tag, ".rd_addr"}, xlog[0].addr, waddr);
    end
    if (xlog.size() == nx_exp && nx_exp > 0) begin
      check({tag, ".wr_we"}, 32'(xlog[nx_exp-1].we), 32'd1);
      check({tag, ".wr_addr"}, xlog[nx_exp-1].addr, waddr);
      check({tag, ".wr_data"}, xlog[nx_exp-1].wdata, expw);
    end
    check({tag, ".mem_word"}, peek(waddr), e ? old : expw);

    @(negedge CLK);
    check({tag, ".no_requeue"}, 32'({busy, bus.mem_req}), 32'h0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] ra;
    bit          req_seen;

    // Reset values
    CLR = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst.busy",  32'(busy), 32'd0);
    check("rst.done",  32'(done), 32'd0);
    check("rst.err",   32'(err), 32'd0);
    check("rst.req",   32'(bus.mem_req), 32'd0);
    check("rst.we",    32'(bus.mem_we), 32'd0);
    check("rst.addr",  bus.mem_addr, 32'h0);
    check("rst.wdata", bus.mem_wdata, 32'h0);
    CLR = 1'b1;
    @(negedge CLK);

    // Directed stores
    mem_model[32'h100] = 32'h11223344;
    run_store("byte", 32'h102, 32'hFFFFFFAB, 2'd0, 0, 1'b0);
    check("byte.const", mem_model[32'h100], 32'h11AB3344);

    mem_model[32'h200] = 32'h11223344;
    run_store("half", 32'h202, 32'h1234BEEF, 2'd1, 0, 1'b0);
    check("half.const", mem_model[32'h200], 32'hBEEF3344);

    run_store("word", 32'h300, 32'hDEADBEEF, 2'd2, 2, 1'b1);
    check("word.const", mem_model[32'h300], 32'hDEADBEEF);

    run_store("half_mis", 32'h101, 32'hCAFE5678, 2'd1, 0, 1'b0);
`ifdef STORE_ALIGN_CHECK_EN
    check("half_mis.const", mem_model[32'h100], 32'h11AB3344);
`else
    check("half_mis.const", mem_model[32'h100], 32'h11AB5678);
`endif

    run_store("word_mis", 32'h302, 32'h0BADF00D, 2'd2, 1, 1'b0);
    run_store("dbl", 32'h400, 32'h55AA55AA, 2'd3, 0, 1'b0);
    run_store("byte_wait", 32'h103, 32'h000000C3, 2'd0, 3, 1'b1);

    // Randomized stores
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      if (i % 2 == 0) ra = 32'h500 + (ra & 32'h1F);
      run_store("rand", ra, $urandom, 2'($urandom_range(0, 3)),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Reset during the read phase of a byte store
    mem_model[32'h600] = 32'hA5A5A5A5;
    wait_cfg = 6;
    xlog.delete();
    @(negedge CLK);
    start = 1'b1; addr = 32'h601; D = 32'h000000EE; dataSize = 2'd0;
    @(negedge CLK);
    start = 1'b0;
    req_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.mem_req === 1'b1) begin
        req_seen = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    check("rstmid.req_seen", 32'(req_seen), 32'd1);
    #2 CLR = 1'b0;
    #1;
    check("rstmid.req",   32'(bus.mem_req), 32'd0);
    check("rstmid.busy",  32'(busy), 32'd0);
    check("rstmid.pulse", 32'({done, err}), 32'h0);
    check("rstmid.wdata", bus.mem_wdata, 32'h0);
    @(negedge CLK);
    CLR = 1'b1;
    check("rstmid.no_xfer", 32'(xlog.size()), 32'd0);
    check("rstmid.mem", mem_model[32'h600], 32'hA5A5A5A5);
    run_store("post_rst", 32'h604, 32'h13579BDF, 2'd2, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
